// File: rtl/trig_source_ctrl.sv
// trig_source_ctrl: trigger source select, sync/filter/edge conditioning, delayed pulse FSM and status counters; define TRIG_DIVIDER_EN for the event divider
module trig_source_ctrl #(
  parameter int CNT_W = 32,
  parameter int MIN_GAP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       reg_trig_mode,
  input  logic             reg_trig_edge,
  input  logic [15:0]      reg_filter_cycles,
  input  logic [CNT_W-1:0] reg_trig_delay,
  input  logic [CNT_W-1:0] reg_pulse_width,
  input  logic [CNT_W-1:0] reg_int_period,
  input  logic             reg_soft_trig,
  input  logic             reg_cnt_clr,
`ifdef TRIG_DIVIDER_EN
  input  logic [15:0]      reg_trig_div,
`endif
  input  logic             ext_trig_in,
  output logic             trigger_out,
  output logic             trig_busy,
  output logic [CNT_W-1:0] trig_cnt,
  output logic [CNT_W-1:0] trig_miss_cnt
);
  typedef enum logic [1:0] {IDLE, DELAY, PULSE, HOLDOFF} state_t;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP = CNT_W'(MIN_GAP);
  state_t state, state_nx;
  logic s1, s2, filt, filt_q, ext_evt, int_evt, evt, start, abort, div_ok;
  logic [15:0] flt_cnt;
  logic [CNT_W-1:0] per_cnt, cnt, w_lat, wid1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      filt <= 1'b0;
      filt_q <= 1'b0;
      ext_evt <= 1'b0;
      flt_cnt <= '0;
    end else begin
      s1 <= ext_trig_in;
      s2 <= s1;
      filt_q <= filt;
      ext_evt <= reg_trig_edge ? (filt_q & ~filt) : (filt & ~filt_q);
      if (s2 == filt) flt_cnt <= '0;
      else if (flt_cnt >= reg_filter_cycles) begin
        filt <= s2;
        flt_cnt <= '0;
      end else flt_cnt <= flt_cnt + 16'd1;
    end
  assign int_evt = reg_trig_mode == 2'd1 && reg_int_period != '0 && per_cnt >= reg_int_period - ONE;
  always_ff @(posedge clk or posedge rst)
    if (rst) per_cnt <= '0;
    else per_cnt <= (reg_trig_mode != 2'd1 || reg_int_period == '0 || int_evt) ? '0 : per_cnt + ONE;
  always_comb
    evt = reg_trig_mode == 2'd1 ? int_evt :
          reg_trig_mode == 2'd2 ? ext_evt :
          reg_trig_mode == 2'd3 ? reg_soft_trig : 1'b0;
`ifdef TRIG_DIVIDER_EN
  logic [15:0] div_cnt;
  logic [1:0] mode_q;
  assign div_ok = div_cnt >= reg_trig_div;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div_cnt <= '0;
      mode_q <= '0;
    end else begin
      mode_q <= reg_trig_mode;
      if (reg_trig_mode != mode_q) div_cnt <= '0;
      else if (state == IDLE && evt) div_cnt <= div_ok ? '0 : div_cnt + 16'd1;
    end
`else
  assign div_ok = 1'b1;
`endif
  assign start = state == IDLE && evt && div_ok;
  assign abort = reg_trig_mode == 2'd0;
  assign wid1 = reg_pulse_width == '0 ? ONE : reg_pulse_width;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = reg_trig_delay == '0 ? PULSE : DELAY;
      DELAY:   if (abort) state_nx = HOLDOFF; else if (cnt == ONE) state_nx = PULSE;
      PULSE:   if (abort || cnt == ONE) state_nx = HOLDOFF;
      HOLDOFF: if (cnt == ONE) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    trigger_out = state == PULSE;
    trig_busy = state != IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      w_lat <= '0;
    end else begin
      if (start) w_lat <= wid1;
      if (state_nx != state)
        cnt <= state_nx == DELAY ? reg_trig_delay :
               state_nx == PULSE ? (state == IDLE ? wid1 : w_lat) :
               state_nx == HOLDOFF ? GAP : '0;
      else if (state != IDLE) cnt <= cnt - ONE;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      trig_cnt <= '0;
      trig_miss_cnt <= '0;
    end else if (reg_cnt_clr) begin
      trig_cnt <= '0;
      trig_miss_cnt <= '0;
    end else begin
      if (state_nx == PULSE && state != PULSE && ~&trig_cnt) trig_cnt <= trig_cnt + ONE;
      if (evt && state != IDLE && ~&trig_miss_cnt) trig_miss_cnt <= trig_miss_cnt + ONE;
    end
endmodule

// File: tb/tb_trig_source_ctrl.sv
// tb_trig_source_ctrl: directed self-checking bench for trig_source_ctrl
module tb_trig_source_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] reg_trig_mode = '0;
  logic reg_trig_edge = 1'b0;
  logic [15:0] reg_filter_cycles = '0;
  logic [31:0] reg_trig_delay = '0;
  logic [31:0] reg_pulse_width = '0;
  logic [31:0] reg_int_period = '0;
  logic reg_soft_trig = 1'b0;
  logic reg_cnt_clr = 1'b0;
  logic ext_trig_in = 1'b0;
`ifdef TRIG_DIVIDER_EN
  logic [15:0] reg_trig_div = '0;
`endif
  logic trigger_out, trig_busy;
  logic [31:0] trig_cnt, trig_miss_cnt;
  int checks = 0;
  int errors = 0;
  int rises = 0;
  logic prev = 1'b0;

  trig_source_ctrl dut (
    .clk(clk), .rst(rst), .reg_trig_mode(reg_trig_mode), .reg_trig_edge(reg_trig_edge),
    .reg_filter_cycles(reg_filter_cycles), .reg_trig_delay(reg_trig_delay),
    .reg_pulse_width(reg_pulse_width), .reg_int_period(reg_int_period),
    .reg_soft_trig(reg_soft_trig), .reg_cnt_clr(reg_cnt_clr),
`ifdef TRIG_DIVIDER_EN
    .reg_trig_div(reg_trig_div),
`endif
    .ext_trig_in(ext_trig_in), .trigger_out(trigger_out), .trig_busy(trig_busy),
    .trig_cnt(trig_cnt), .trig_miss_cnt(trig_miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1);
      if (trigger_out && !prev) rises++;
      prev = trigger_out;
    end
  endtask

  task automatic clr_cnt;
    reg_cnt_clr = 1'b1;
    cyc(1);
    reg_cnt_clr = 1'b0;
    cyc(1);
    rises = 0;
    prev = trigger_out;
  endtask

  task automatic test_reset;
    cyc(3);
    checks++;
    if (trigger_out !== 1'b0) begin errors++; $display("FAIL reset_trigger_out: got %b expected 0", trigger_out); end
    checks++;
    if (trig_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", trig_busy); end
    checks++;
    if (trig_cnt !== 32'd0) begin errors++; $display("FAIL reset_trig_cnt: got %0d expected 0", trig_cnt); end
    checks++;
    if (trig_miss_cnt !== 32'd0) begin errors++; $display("FAIL reset_miss_cnt: got %0d expected 0", trig_miss_cnt); end
    reg_trig_mode = 2'd2;
    reg_trig_edge = 1'b1;
    rst = 1'b0;
    cyc(10);
    checks++;
    if (trig_cnt !== 32'd0) begin errors++; $display("FAIL reset_no_false_fall: got %0d expected 0", trig_cnt); end
    reg_trig_mode = 2'd0;
    reg_trig_edge = 1'b0;
    cyc(2);
  endtask

  task automatic test_soft;
    reg_trig_mode = 2'd3;
    reg_trig_delay = 0;
    reg_pulse_width = 3;
    clr_cnt();
    cyc(10);
    reg_soft_trig = 1'b1;
    cyc(1);
    reg_soft_trig = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (trigger_out !== (i <= 3)) begin errors++; $display("FAIL soft_trigger_out[%0d]: got %b expected %b", i, trigger_out, i <= 3); end
      checks++;
      if (trig_busy !== (i <= 7)) begin errors++; $display("FAIL soft_busy[%0d]: got %b expected %b", i, trig_busy, i <= 7); end
      cyc(1);
    end
    checks++;
    if (trig_cnt !== 32'd1) begin errors++; $display("FAIL soft_trig_cnt: got %0d expected 1", trig_cnt); end
    checks++;
    if (trig_miss_cnt !== 32'd0) begin errors++; $display("FAIL soft_miss_cnt: got %0d expected 0", trig_miss_cnt); end
  endtask

  task automatic test_ext;
    reg_trig_mode = 2'd2;
    reg_trig_edge = 1'b0;
    reg_filter_cycles = 5;
    reg_pulse_width = 2;
    clr_cnt();
    ext_trig_in = 1'b1;
    run(3);
    ext_trig_in = 1'b0;
    run(30);
    checks++;
    if (rises !== 0 || trig_cnt !== 32'd0) begin errors++; $display("FAIL ext_glitch: got %0d pulses cnt %0d expected 0", rises, trig_cnt); end
    ext_trig_in = 1'b1;
    run(10);
    ext_trig_in = 1'b0;
    run(30);
    checks++;
    if (rises !== 1) begin errors++; $display("FAIL ext_pulses: got %0d expected 1", rises); end
    checks++;
    if (trig_cnt !== 32'd1) begin errors++; $display("FAIL ext_trig_cnt: got %0d expected 1", trig_cnt); end
    reg_filter_cycles = 0;
    cyc(2);
    ext_trig_in = 1'b1;
    cyc(4);
    checks++;
    if (trigger_out !== 1'b0) begin errors++; $display("FAIL ext_latency_early: got %b expected 0", trigger_out); end
    cyc(1);
    checks++;
    if (trigger_out !== 1'b1) begin errors++; $display("FAIL ext_latency: got %b expected 1", trigger_out); end
    ext_trig_in = 1'b0;
    cyc(20);
  endtask

  task automatic test_internal;
    int first, last;
    first = -1;
    last = -1;
    reg_trig_mode = 2'd0;
    reg_trig_delay = 7;
    reg_pulse_width = 2;
    reg_int_period = 100;
    clr_cnt();
    reg_trig_mode = 2'd1;
    prev = 1'b0;
    for (int i = 0; i < 1010; i++) begin
      if (trigger_out && !prev) begin
        if (rises == 0) first = i;
        last = i;
        rises++;
      end
      prev = trigger_out;
      cyc(1);
    end
    checks++;
    if (rises !== 10) begin errors++; $display("FAIL int_pulses: got %0d expected 10", rises); end
    checks++;
    if (first !== 107 || last !== 1007) begin errors++; $display("FAIL int_timing: got first %0d last %0d expected 107 1007", first, last); end
    checks++;
    if (trig_cnt !== 32'd10) begin errors++; $display("FAIL int_trig_cnt: got %0d expected 10", trig_cnt); end
    reg_trig_mode = 2'd0;
    reg_trig_delay = 0;
    cyc(20);
  endtask

  task automatic test_back_to_back;
    reg_trig_mode = 2'd3;
    reg_pulse_width = 20;
    clr_cnt();
    reg_soft_trig = 1'b1;
    run(1);
    reg_soft_trig = 1'b0;
    run(4);
    reg_soft_trig = 1'b1;
    run(1);
    reg_soft_trig = 1'b0;
    checks++;
    if (trig_miss_cnt !== 32'd1) begin errors++; $display("FAIL b2b_miss_cnt: got %0d expected 1", trig_miss_cnt); end
    checks++;
    if (trig_cnt !== 32'd1) begin errors++; $display("FAIL b2b_trig_cnt: got %0d expected 1", trig_cnt); end
    run(1);
    reg_soft_trig = 1'b1;
    reg_cnt_clr = 1'b1;
    run(1);
    reg_soft_trig = 1'b0;
    reg_cnt_clr = 1'b0;
    checks++;
    if (trig_cnt !== 32'd0 || trig_miss_cnt !== 32'd0) begin errors++; $display("FAIL b2b_clr: got %0d/%0d expected 0/0", trig_cnt, trig_miss_cnt); end
    checks++;
    if (trigger_out !== 1'b1) begin errors++; $display("FAIL b2b_still_pulse: got %b expected 1", trigger_out); end
    run(30);
    checks++;
    if (rises !== 1 || trig_busy !== 1'b0) begin errors++; $display("FAIL b2b_single: got %0d pulses busy %b expected 1 pulses busy 0", rises, trig_busy); end
  endtask

  task automatic test_falling_abort;
    rst = 1'b1;
    ext_trig_in = 1'b1;
    reg_trig_mode = 2'd2;
    reg_trig_edge = 1'b1;
    reg_filter_cycles = 0;
    reg_pulse_width = 10;
    cyc(2);
    rst = 1'b0;
    cyc(10);
    checks++;
    if (trig_cnt !== 32'd0 || trig_busy !== 1'b0) begin errors++; $display("FAIL fall_held_high: got cnt %0d busy %b expected 0 0", trig_cnt, trig_busy); end
    ext_trig_in = 1'b0;
    cyc(4);
    checks++;
    if (trigger_out !== 1'b0) begin errors++; $display("FAIL fall_early: got %b expected 0", trigger_out); end
    cyc(1);
    checks++;
    if (trigger_out !== 1'b1) begin errors++; $display("FAIL fall_pulse: got %b expected 1", trigger_out); end
    cyc(2);
    reg_trig_mode = 2'd0;
    cyc(1);
    checks++;
    if (trigger_out !== 1'b0 || trig_busy !== 1'b1) begin errors++; $display("FAIL abort_drop: got out %b busy %b expected 0 1", trigger_out, trig_busy); end
    cyc(3);
    checks++;
    if (trig_busy !== 1'b1) begin errors++; $display("FAIL abort_holdoff: got %b expected 1", trig_busy); end
    cyc(1);
    checks++;
    if (trig_busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got %b expected 0", trig_busy); end
    cyc(20);
    checks++;
    if (trig_cnt !== 32'd1 || trigger_out !== 1'b0) begin errors++; $display("FAIL abort_no_more: got cnt %0d out %b expected 1 0", trig_cnt, trigger_out); end
  endtask

`ifdef TRIG_DIVIDER_EN
  task automatic test_divider;
    reg_trig_mode = 2'd0;
    reg_trig_div = 2;
    reg_pulse_width = 2;
    reg_trig_delay = 0;
    clr_cnt();
    reg_trig_mode = 2'd3;
    run(1);
    for (int k = 0; k < 9; k++) begin
      reg_soft_trig = 1'b1;
      run(1);
      reg_soft_trig = 1'b0;
      run(49);
    end
    checks++;
    if (rises !== 3) begin errors++; $display("FAIL div_pulses: got %0d expected 3", rises); end
    checks++;
    if (trig_cnt !== 32'd3 || trig_miss_cnt !== 32'd0) begin errors++; $display("FAIL div_counts: got %0d/%0d expected 3/0", trig_cnt, trig_miss_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_soft();
    test_ext();
    test_internal();
    test_back_to_back();
    test_falling_abort();
`ifdef TRIG_DIVIDER_EN
    test_divider();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/trig_source_ctrl.md
Name: trig_source_ctrl

Overview:
- Trigger front-end for the trig_ctrl path; sits directly upstream of the sensor exposure stage and drives its trigger input.
- Selects one trigger source: off, internal periodic, external hardware line, or software.
- Conditions the selected source with a synchroniser, glitch filter, edge select, programmable delay, pulse width and minimum low gap.
- Keeps saturating counters of issued and dropped triggers for status readback.

Parameters:
- CNT_W, 32, width of delay/width/period registers and status counters
- MIN_GAP, 4, trigger_out low cycles forced after every pulse; must be ≥4 so the downstream 4-tap rising-edge detector sees every pulse

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- reg_trig_mode  in  2  0 off, 1 internal periodic, 2 external, 3 software
- reg_trig_edge  in  1  0 rising, 1 falling (external mode only)
- reg_filter_cycles  in  16  glitch filter length
- reg_trig_delay  in  CNT_W  event-to-pulse delay, clk cycles
- reg_pulse_width  in  CNT_W  trigger_out high time, clk cycles (0 treated as 1)
- reg_int_period  in  CNT_W  internal trigger period, clk cycles (0 = no events)
- reg_soft_trig  in  1  single-cycle software trigger strobe
- reg_cnt_clr  in  1  synchronous clear of both status counters
- ext_trig_in  in  1  asynchronous external trigger line
- trigger_out  out  1  conditioned trigger to the exposure stage
- trig_busy  out  1  FSM not in IDLE
- trig_cnt  out  CNT_W  pulses issued, saturating
- trig_miss_cnt  out  CNT_W  events dropped while busy, saturating

Behaviour:
- Reset rst, asynchronous, active-high; clock clk.
- Reset values: all outputs 0; synchroniser, filter and edge registers 0; FSM in IDLE.
- Sync: 2-FF synchroniser on ext_trig_in.
- Filter: filtered level takes the synced level only after that level has been stable for reg_filter_cycles+1 consecutive cycles. reg_filter_cycles=0 gives one cycle.
- Edge: ext_evt = filtered rising edge (edge=0) or falling edge (edge=1), compared against a registered copy. The post-reset 0 level never produces a false falling edge.
- Internal: period counter runs 0..reg_int_period-1 and fires int_evt at terminal count. The counter holds 0 when mode≠1 or period=0.
- Software: soft_evt = reg_soft_trig, mode 3 only.
- evt is the selected source; mode 0 gives no events.
- FSM states IDLE, DELAY, PULSE, HOLDOFF:
  - IDLE + evt: latch delay and width. delay=0 → PULSE (trigger_out=1 next cycle); else → DELAY.
  - DELAY: counts latched delay cycles, then → PULSE.
  - PULSE: trigger_out=1 for exactly max(width,1) cycles, then → HOLDOFF.
  - HOLDOFF: trigger_out=0 for MIN_GAP cycles, then → IDLE.
  - An evt on the same cycle HOLDOFF exits is dropped.
- Latency: soft strobe at cycle N → trigger_out high at N+1 (delay 0). External with filter 0 and delay 0: trigger_out high on the 4th clk edge after the edge that first samples ext_trig_in high.
- evt while not IDLE: dropped and trig_miss_cnt++. No queuing.
- Mode write to 0 while in DELAY/PULSE: trigger_out drops next cycle, FSM → HOLDOFF, no further pulse.
- Mode change in any other state takes effect on the next evt. Register changes mid-pulse are ignored (latched values used).
- trig_cnt++ on entry to PULSE.
- Counters saturate at all-ones. reg_cnt_clr wins over a simultaneous increment.

Optional Feature:
- Macro TRIG_DIVIDER_EN.
- Defined: adds input reg_trig_div[15:0] and a divider counter reset by rst.
  - Only every (reg_trig_div+1)th event accepted in IDLE starts a pulse.
  - Skipped events do not touch either counter.
  - The divider counter clears when mode changes.
- Undefined: port absent; every accepted event starts a pulse.

Test Plan:
- Mode 3, delay 0, width 3, soft strobe at cycle 10 → trigger_out high at cycles 11–13, low ≥4 cycles; trig_cnt=1.
- Mode 2, rising, filter 5, 3-cycle glitch on ext_trig_in → no pulse. 10-cycle high → one pulse; trig_cnt=1.
- Mode 1, period 100, delay 7, width 2 → pulses every 100 cycles, each starting 8 cycles after the terminal count; 10 periods → trig_cnt=10.
- Mode 3, width 20, second strobe 5 cycles after the first → single pulse; trig_miss_cnt=1. reg_cnt_clr together with a third dropped strobe → both counters read 0.
- Mode 2, falling, ext line held high from reset then dropped → exactly one pulse. Mode set to 0 mid-pulse → trigger_out low next cycle, then HOLDOFF, then IDLE.
- TRIG_DIVIDER_EN defined, reg_trig_div=2, 9 soft strobes spaced 50 cycles apart → 3 pulses, trig_cnt=3, trig_miss_cnt=0.
